// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state type, default line timing and
// 8N1 frame geometry.
package uart_pkg;

  localparam int DEFAULT_CLK_FREQ = 100_000_000;
  localparam int DEFAULT_BAUD     = 9600;

  // 8N1: one start bit, eight data bits, one stop bit.
  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Producer-side write port of the transmit queue. Producers only ever see
// the FIFO status; the serial line is a separate plain port.
interface uart_tx_queue_if #(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          overflow;

  modport master (
    output wr_en, wr_data,
    input  full, empty, level, overflow
  );

  modport slave (
    input  wr_en, wr_data,
    output full, empty, level, overflow
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read: rd_data always presents the head
// entry, and rd_en consumes it at the next edge. Occupancy is kept in its own
// counter so full/empty fall straight out of a register compare.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level,
  output logic             overflow
);

  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // full is judged on the pre-edge level, so a write to a full FIFO is lost
  // even when the same edge pops an entry.
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign rd_data = mem[rd_ptr];

  // Pointers, occupancy counter and the dropped-write pulse.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en && full;
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage array write.
  // NOTE: the array has no reset; contents are only ever read behind the
  // level counter, so stale data is unreachable and the array can map to RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Buffered 8N1 UART transmitter. Producers push bytes into a small FIFO;
// the serializer pops one byte per frame and shifts it out LSB first on
// RsTx. Consecutive frames are emitted with no idle gap while data is queued.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
  parameter int BAUD     = DEFAULT_BAUD,
  parameter int DEPTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  uart_tx_queue_if.slave        wr,
  output logic                  busy,
  output logic                  RsTx
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int BCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BCW-1:0] BAUD_LAST = BCW'(DIV - 1);
  localparam logic [2:0]     LAST_BIT  = 3'(DATA_BITS - 1);

  tx_state_t      state;
  logic [BCW-1:0] baud_cnt;
  logic [2:0]     bit_cnt;
  logic [7:0]     shift;
  logic [7:0]     head;
  logic           bit_end;
  logic           pop;

  // A pop happens either from IDLE as soon as data is present, or on the
  // last STOP cycle so the next start bit follows without a gap.
  assign bit_end = (baud_cnt == BAUD_LAST);
  assign pop     = !wr.empty && ((state == IDLE) || ((state == STOP) && bit_end));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr.wr_en),
    .wr_data  (wr.wr_data),
    .rd_en    (pop),
    .rd_data  (head),
    .full     (wr.full),
    .empty    (wr.empty),
    .level    (wr.level),
    .overflow (wr.overflow)
  );

  // Frame sequencer: baud timing, bit counting, shifting and the line flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      busy     <= 1'b0;
      RsTx     <= 1'b1;
    end else begin
      // Baud counter wraps at every bit boundary; IDLE pins it at zero so
      // each frame's timing is anchored to its own start bit.
      baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;

      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (pop) begin
            shift <= head;
            RsTx  <= 1'b0;
            busy  <= 1'b1;
            state <= START;
          end
        end

        START: begin
          if (bit_end) begin
            RsTx    <= shift[0];
            bit_cnt <= '0;
            state   <= DATA;
          end
        end

        DATA: begin
          if (bit_end) begin
            shift   <= shift >> 1;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              RsTx  <= 1'b1;
              state <= STOP;
            end else begin
              RsTx  <= shift[1];
            end
          end
        end

        STOP: begin
          if (bit_end) begin
            if (pop) begin
              shift <= head;
              RsTx  <= 1'b0;
              state <= START;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end

        default: begin
          busy  <= 1'b0;
          RsTx  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue at DIV = 16, DEPTH = 4. A queue/timeline model
// predicts FIFO occupancy, frame start times and the expected line level;
// a free-running line decoder turns RsTx back into bytes.
`timescale 1ns/1ps
module tb_uart_tx_queue;
  import uart_pkg::*;

  localparam int CLK_FREQ  = 16;
  localparam int BAUD      = 1;
  localparam int DEPTH     = 4;
  localparam int DIV       = CLK_FREQ / BAUD;
  localparam int FRAME_CYC = FRAME_BITS * DIV;
  localparam int LW        = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  logic RsTx;

  uart_tx_queue_if #(.DEPTH(DEPTH)) wr ();

  uart_tx_queue #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .DEPTH    (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (wr),
    .busy  (busy),
    .RsTx  (RsTx)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  logic [7:0] mq[$];        // bytes waiting in the FIFO
  logic [7:0] sent_q[$];    // bytes the model has started transmitting
  logic [7:0] rx_q[$];      // bytes decoded from the line
  int         cyc = 0;      // rising edges seen
  int         next_free = 0;
  int         frame_start = -1000000;
  logic [7:0] frame_byte = 8'h00;
  logic       exp_ovf = 1'b0;
  bit         mon_en = 1'b0;

  // Line level expected after the most recent edge, from the 8N1 frame rule.
  function automatic logic exp_line();
    int off;
    int idx;
    off = cyc - frame_start;
    if (off < 0 || off >= FRAME_CYC) return 1'b1;
    idx = off / DIV;
    if (idx == 0) return 1'b0;
    if (idx == FRAME_BITS - 1) return 1'b1;
    return frame_byte[idx-1];
  endfunction

  // Model update at every rising edge: pop if the transmitter is free and
  // data was queued before the edge, then apply the write against the
  // pre-edge fullness.
  initial forever begin : model
    bit was_full;
    @(posedge clk);
    cyc++;
    if (rst_n !== 1'b1) begin
      mq.delete();
      next_free   = 0;
      frame_start = -1000000;
      exp_ovf     = 1'b0;
    end else begin
      was_full = (mq.size() == DEPTH);
      exp_ovf  = wr.wr_en && was_full;
      if (cyc >= next_free && mq.size() > 0) begin
        frame_byte  = mq.pop_front();
        sent_q.push_back(frame_byte);
        frame_start = cyc;
        next_free   = cyc + FRAME_CYC;
      end
      if (wr.wr_en && !was_full) mq.push_back(wr.wr_data);
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  initial forever begin : monitor
    logic [LW-1:0] exp_lvl;
    @(negedge clk);
    if (rst_n === 1'b1 && mon_en) begin
      exp_lvl = LW'(mq.size());
      checks++;
      if (RsTx !== exp_line()) begin
        errors++;
        $display("FAIL mon_line cyc=%0d: RsTx=%b required %b", cyc, RsTx, exp_line());
      end
      checks++;
      if (busy !== (cyc < next_free)) begin
        errors++;
        $display("FAIL mon_busy cyc=%0d: busy=%b required %b", cyc, busy, cyc < next_free);
      end
      checks++;
      if (wr.level !== exp_lvl) begin
        errors++;
        $display("FAIL mon_level cyc=%0d: level=%0d required %0d", cyc, wr.level, exp_lvl);
      end
      checks++;
      if (wr.empty !== (mq.size() == 0)) begin
        errors++;
        $display("FAIL mon_empty cyc=%0d: empty=%b required %b", cyc, wr.empty, mq.size() == 0);
      end
      checks++;
      if (wr.full !== (mq.size() == DEPTH)) begin
        errors++;
        $display("FAIL mon_full cyc=%0d: full=%b required %b", cyc, wr.full, mq.size() == DEPTH);
      end
      checks++;
      if (wr.overflow !== exp_ovf) begin
        errors++;
        $display("FAIL mon_overflow cyc=%0d: overflow=%b required %b", cyc, wr.overflow, exp_ovf);
      end
    end
  end

  // Line decoder: finds a start bit, samples mid-bit, checks the stop bit.
  // Frames interrupted by reset are discarded.
  initial forever begin : decoder
    logic [9:0] bits;
    bit         ok;
    @(negedge clk);
    if (rst_n === 1'b1 && RsTx === 1'b0) begin
      ok = 1'b1;
      repeat (DIV / 2) @(negedge clk);
      for (int b = 0; b < FRAME_BITS; b++) begin
        if (b > 0) repeat (DIV) @(negedge clk);
        if (rst_n !== 1'b1) ok = 1'b0;
        bits[b] = RsTx;
      end
      if (ok) begin
        checks++;
        if (bits[0] !== 1'b0 || bits[9] !== 1'b1) begin
          errors++;
          $display("FAIL dec_framing: start=%b stop=%b required 0/1", bits[0], bits[9]);
        end
        rx_q.push_back(bits[8:1]);
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((busy !== 1'b0 || wr.empty !== 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_timeout: busy=%b empty=%b after %0d cycles, required idle", busy, wr.empty, n);
    end
    repeat (20) @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int zeros;
    rst_n = 1'b0;
    wr.wr_en = 1'b0;
    wr.wr_data = 8'h00;
    repeat (5) @(negedge clk);
    checks++;
    if (RsTx !== 1'b1) begin errors++; $display("FAIL rst_line: RsTx=%b required 1", RsTx); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: busy=%b required 0", busy); end
    checks++;
    if (wr.empty !== 1'b1 || wr.full !== 1'b0) begin
      errors++; $display("FAIL rst_flags: empty=%b full=%b required 1/0", wr.empty, wr.full);
    end
    checks++;
    if (wr.level !== '0 || wr.overflow !== 1'b0) begin
      errors++; $display("FAIL rst_level: level=%0d overflow=%b required 0/0", wr.level, wr.overflow);
    end
    #3 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (RsTx !== 1'b1 || busy !== 1'b0 || wr.empty !== 1'b1 || wr.level !== '0) begin
      errors++;
      $display("FAIL rst_release: RsTx=%b busy=%b empty=%b level=%0d required 1/0/1/0",
               RsTx, busy, wr.empty, wr.level);
    end
    mon_en = 1'b1;
    zeros = 0;
    repeat (200) begin
      @(negedge clk);
      if (RsTx !== 1'b1) zeros++;
    end
    checks++;
    if (zeros != 0) begin
      errors++; $display("FAIL rst_idle_line: %0d low cycles required 0", zeros);
    end
  endtask

  task automatic test_single();
    int exp_bits[10] = '{0, 1, 1, 1, 0, 1, 0, 1, 0, 1};
    rx_q.delete();
    @(negedge clk);
    wr.wr_en = 1'b1;
    wr.wr_data = 8'h57;
    @(posedge clk); #1;
    checks++;
    if (wr.empty !== 1'b0 || RsTx !== 1'b1) begin
      errors++; $display("FAIL single_accept: empty=%b RsTx=%b required 0/1", wr.empty, RsTx);
    end
    @(negedge clk);
    wr.wr_en = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (RsTx !== 1'b0 || busy !== 1'b1 || wr.empty !== 1'b1) begin
      errors++;
      $display("FAIL single_pop: RsTx=%b busy=%b empty=%b required 0/1/1", RsTx, busy, wr.empty);
    end
    repeat (DIV / 2) @(posedge clk);
    for (int k = 0; k < FRAME_BITS; k++) begin
      if (k > 0) repeat (DIV) @(posedge clk);
      #1;
      checks++;
      if (RsTx !== exp_bits[k][0]) begin
        errors++; $display("FAIL single_bit%0d: RsTx=%b required %0d", k, RsTx, exp_bits[k]);
      end
    end
    repeat (7) @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_end: busy=%b required 1", busy); end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || wr.empty !== 1'b1 || RsTx !== 1'b1) begin
      errors++;
      $display("FAIL single_done: busy=%b empty=%b RsTx=%b required 0/1/1", busy, wr.empty, RsTx);
    end
    wait_drain(400);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h57) begin
      errors++;
      $display("FAIL single_rx: got %0d bytes first=%h required 1 byte 57",
               rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back();
    int hi;
    int first_low;
    int lvl_bad;
    int peak;
    int exp_l;
    logic [7:0] exp_b[3] = '{8'h41, 8'h42, 8'h43};
    rx_q.delete();
    hi = 0; first_low = -1; lvl_bad = 0; peak = 0;
    @(negedge clk);
    wr.wr_en = 1'b1;
    wr.wr_data = 8'h41;
    @(negedge clk);
    wr.wr_data = 8'h42;
    for (int i = 0; i < 520; i++) begin
      @(negedge clk);
      if (i == 0) wr.wr_data = 8'h43;
      if (i == 1) wr.wr_en = 1'b0;
      exp_l = (i == 0) ? 1 : (i < 160) ? 2 : (i < 320) ? 1 : 0;
      if (int'(wr.level) != exp_l) lvl_bad++;
      if (int'(wr.level) > peak) peak = int'(wr.level);
      if (busy === 1'b1) hi++;
      else if (first_low < 0) first_low = i;
    end
    checks++;
    if (hi != 3 * FRAME_CYC || first_low != 3 * FRAME_CYC) begin
      errors++;
      $display("FAIL b2b_span: busy for %0d cycles, first low at %0d, required %0d contiguous",
               hi, first_low, 3 * FRAME_CYC);
    end
    checks++;
    if (peak != 2 || lvl_bad != 0) begin
      errors++; $display("FAIL b2b_level: peak=%0d bad_samples=%0d required peak 2, 0 bad", peak, lvl_bad);
    end
    wait_drain(600);
    checks++;
    if (rx_q.size() != 3) begin
      errors++; $display("FAIL b2b_count: got %0d bytes required 3", rx_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rx_q[k] !== exp_b[k]) begin
          errors++; $display("FAIL b2b_byte%0d: got %h required %h", k, rx_q[k], exp_b[k]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    int ovf_cnt;
    bit full_ok;
    rx_q.delete();
    ovf_cnt = 0;
    full_ok = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (wr.overflow === 1'b1) ovf_cnt++;
      if (k == 5) full_ok = (wr.full === 1'b1) && (int'(wr.level) == DEPTH);
      wr.wr_en = 1'b1;
      wr.wr_data = 8'h10 + 8'(k);
    end
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (j == 0) wr.wr_en = 1'b0;
      if (wr.overflow === 1'b1) ovf_cnt++;
    end
    checks++;
    if (!full_ok) begin
      errors++; $display("FAIL ovf_full: full=%b level=%0d required full at level 4", wr.full, wr.level);
    end
    checks++;
    if (ovf_cnt != 1) begin
      errors++; $display("FAIL ovf_pulse: %0d overflow cycles required 1", ovf_cnt);
    end
    wait_drain(6 * FRAME_CYC + 100);
    checks++;
    if (rx_q.size() != 5) begin
      errors++; $display("FAIL ovf_count: got %0d bytes required 5", rx_q.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (rx_q[k] !== 8'h10 + 8'(k)) begin
          errors++; $display("FAIL ovf_byte%0d: got %h required %h", k, rx_q[k], 8'h10 + 8'(k));
        end
      end
    end
  endtask

  task automatic test_full_pop();
    int s;
    rx_q.delete();
    s = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 2) s = cyc;  // edge that popped the first byte
      wr.wr_en = 1'b1;
      wr.wr_data = 8'hA0 + 8'(k);
    end
    @(negedge clk);
    wr.wr_en = 1'b0;
    while (cyc < s + FRAME_CYC - 1) @(negedge clk);
    checks++;
    if (wr.full !== 1'b1 || int'(wr.level) != DEPTH) begin
      errors++; $display("FAIL fp_before: full=%b level=%0d required 1/4", wr.full, wr.level);
    end
    wr.wr_en = 1'b1;
    wr.wr_data = 8'hEE;
    @(posedge clk); #1;
    checks++;
    if (int'(wr.level) != DEPTH - 1 || wr.overflow !== 1'b1 || wr.full !== 1'b0) begin
      errors++;
      $display("FAIL fp_edge: level=%0d overflow=%b full=%b required 3/1/0", wr.level, wr.overflow, wr.full);
    end
    checks++;
    if (RsTx !== 1'b0) begin errors++; $display("FAIL fp_restart: RsTx=%b required 0", RsTx); end
    @(negedge clk);
    wr.wr_en = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (wr.overflow !== 1'b0) begin
      errors++; $display("FAIL fp_pulse_len: overflow=%b required 0", wr.overflow);
    end
    wait_drain(5 * FRAME_CYC + 100);
    checks++;
    if (rx_q.size() != 5) begin
      errors++; $display("FAIL fp_count: got %0d bytes required 5", rx_q.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (rx_q[k] !== 8'hA0 + 8'(k)) begin
          errors++; $display("FAIL fp_byte%0d: got %h required %h", k, rx_q[k], 8'hA0 + 8'(k));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int s;
    int lows;
    int busys;
    rx_q.delete();
    @(negedge clk);
    wr.wr_en = 1'b1;
    wr.wr_data = 8'h00;
    @(negedge clk);
    wr.wr_data = 8'h55;
    @(negedge clk);
    s = cyc;
    wr.wr_en = 1'b0;
    while (cyc < s + 5 * DIV - 10) @(negedge clk);  // inside data bit 3
    checks++;
    if (RsTx !== 1'b0 || int'(wr.level) != 1) begin
      errors++; $display("FAIL rm_before: RsTx=%b level=%0d required 0/1", RsTx, wr.level);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (RsTx !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL rm_async: RsTx=%b busy=%b required 1/0", RsTx, busy);
    end
    checks++;
    if (wr.level !== '0 || wr.empty !== 1'b1) begin
      errors++; $display("FAIL rm_flush: level=%0d empty=%b required 0/1", wr.level, wr.empty);
    end
    repeat (3) @(negedge clk);
    #3 rst_n = 1'b1;
    lows = 0;
    busys = 0;
    repeat (300) begin
      @(negedge clk);
      if (RsTx !== 1'b1) lows++;
      if (busy !== 1'b0 || wr.level !== '0) busys++;
    end
    checks++;
    if (lows != 0 || busys != 0) begin
      errors++;
      $display("FAIL rm_after: %0d low cycles, %0d busy/level cycles, required 0/0", lows, busys);
    end
    checks++;
    if (rx_q.size() != 0) begin
      errors++; $display("FAIL rm_rx: got %0d bytes required 0", rx_q.size());
    end
  endtask

  task automatic test_random();
    int gap;
    sent_q.delete();
    rx_q.delete();
    for (int n = 0; n < 24; n++) begin
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60, 300)) : int'($urandom_range(0, 3));
      @(negedge clk);
      wr.wr_en = 1'b1;
      wr.wr_data = 8'($urandom);
      if (gap > 0) begin
        @(negedge clk);
        wr.wr_en = 1'b0;
        repeat (gap - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    wr.wr_en = 1'b0;
    wait_drain((DEPTH + 2) * FRAME_CYC + 100);
    checks++;
    if (rx_q.size() != sent_q.size()) begin
      errors++; $display("FAIL rand_count: got %0d bytes required %0d", rx_q.size(), sent_q.size());
    end else begin
      for (int k = 0; k < sent_q.size(); k++) begin
        checks++;
        if (rx_q[k] !== sent_q[k]) begin
          errors++; $display("FAIL rand_byte%0d: got %h required %h", k, rx_q[k], sent_q[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Buffered UART transmit path: accepts bytes from on-chip producers (key echo, game-event reporting) into a small FIFO and serializes them as 8N1 frames on `RsTx` at a fixed baud rate. It is the counterpart of the existing receive path: the receiver decodes `RsRx` into bytes, and this block returns bytes to the host. Producers never wait on the line; they see only `full`, and a write while `full` is dropped and flagged.

## Interface
- `CLK_FREQ`, 100_000_000: system clock frequency in Hz.
- `BAUD`, 9600: line rate in bit/s; `DIV = CLK_FREQ / BAUD` (integer, must be ≥ 2), which is 10416 at the defaults.
- `DEPTH`, 16: FIFO depth in bytes; must be a power of 2 and ≥ 2. `AW = log2(DEPTH)`.
- `clk  in  1`: system clock, rising edge.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `wr_en  in  1`: write strobe, one byte per cycle high.
- `wr_data  in  8`: byte to enqueue.
- `full  out  1`: FIFO holds DEPTH bytes.
- `empty  out  1`: FIFO holds 0 bytes.
- `level  out  AW+1`: current FIFO occupancy, 0..DEPTH.
- `overflow  out  1`: one-cycle pulse when a write is dropped.
- `busy  out  1`: serializer is not IDLE.
- `RsTx  out  1`: serial output, idle high.

## Operation
- Reset values, applied asynchronously while `rst_n` = 0:
  - `RsTx` = 1, `busy` = 0, `empty` = 1, `full` = 0, `level` = 0, `overflow` = 0.
  - FSM in IDLE; baud counter, bit counter and FIFO pointers all 0.
- Write path:
  - `wr_en` && !`full` stores `wr_data` at the write pointer and increments the pointer (wraps modulo DEPTH).
  - `wr_en` && `full` drops the byte and pulses `overflow` for one cycle.
  - `full` is evaluated before any pop in the same cycle, so a write while `full` is dropped even if a pop occurs in that cycle.
- Simultaneous write (non-full) and pop: `level` is unchanged and both pointers advance.
- `level` is held in a separate counter. `full` = (`level` == DEPTH) and `empty` = (`level` == 0); both are registered-consistent with `level`.
- FSM states and transitions:
  - IDLE: if !`empty`, pop the FIFO head into an 8-bit shift register, set `RsTx` = 0, clear the baud counter, go to START.
  - START: hold for DIV cycles, then output shift[0], set bit counter = 0, go to DATA.
  - DATA: each bit lasts DIV cycles; at the end of a bit, shift right and increment the bit counter. After bit 7, set `RsTx` = 1 and go to STOP.
  - STOP: hold for DIV cycles. At the end, if !`empty`, pop and go directly to START (no idle gap between frames); otherwise go to IDLE.
- Baud counter: counts 0..DIV-1 and restarts at every frame start, so bit boundaries are phase-locked to the start bit rather than free-running.
- Bit order is LSB first. A frame is 1 start bit (0), 8 data bits, 1 stop bit (1): exactly 10×DIV cycles.
- `busy` = 1 in START, DATA and STOP.
- Reset asserted mid-frame: the frame is aborted, `RsTx` returns to 1 immediately (asynchronously), and FIFO contents are discarded.

## Timing
- Latency: a write accepted at edge N into an empty, idle block gives `empty` = 0 after edge N. The FSM pops at edge N+1, and `RsTx` falls at edge N+1.
- `RsTx` is driven directly from a flop: no combinational path from any input to `RsTx`.
- The FIFO slot is freed at the pop edge (start of the start bit), not at the end of the frame.
- Back-to-back frames: the start bit of frame k+1 begins on the edge right after the last STOP cycle of frame k.
- Sustained throughput is one byte per 10×DIV cycles. Bursts of up to DEPTH bytes, plus one in the shift register, are absorbed without loss.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state type (IDLE, START, DATA, STOP);
  - the default `CLK_FREQ` and `BAUD` constants;
  - the frame constants `FRAME_BITS` = 10 and `DATA_BITS` = 8.
- One sub-module: `sync_fifo` (parameters WIDTH, DEPTH; ports clk, rst_n, wr_en, wr_data, rd_en, rd_data, full, empty, level, overflow), with rd_data valid on the same cycle as rd_en (show-ahead).
- The top level holds the baud counter, bit counter, shift register and FSM.

## Test plan
All scenarios use `CLK_FREQ` = 16, `BAUD` = 1 (DIV = 16) and `DEPTH` = 4.
- **Reset:** hold `rst_n` = 0 for 5 cycles, then release → `RsTx` = 1, `busy` = 0, `empty` = 1, `level` = 0; `RsTx` stays 1 for 200 cycles with no writes.
- **Single byte:** write 0x57 → `RsTx` falls on the next edge. Sampled at the middle of each bit (every 16 cycles), the line reads 0,1,1,1,0,1,0,1,0,1. `busy` drops 160 cycles after the frame starts and `empty` stays 1.
- **Back-to-back:** write 0x41, 0x42, 0x43 on consecutive cycles → three contiguous frames totalling 480 cycles with no idle gap. `level` peaks at 2 and then steps down at each frame start.
- **Overflow:** write 6 bytes 0x10..0x15 on consecutive cycles.
  - 0x10 is popped immediately and 0x11..0x14 fill the FIFO.
  - 0x15 is dropped with a 1-cycle `overflow` pulse.
  - Output sequence is 0x10..0x14.
- **Simultaneous write and pop while full:** with the FIFO full, write exactly on the STOP→START pop edge → the byte is dropped, `overflow` pulses, and `level` = 3 after the edge.
- **Reset mid-frame:** assert `rst_n` = 0 during bit 3 of 0x00 → `RsTx` = 1 immediately. After release, `level` = 0 and nothing is transmitted.
